// File: rtl/cost_pkg.sv
// rtl/cost_pkg.sv - mode encoding and elaboration helpers shared by the cost minimiser
package cost_pkg;

   localparam logic MODE_MIN = 1'b0;
   localparam logic MODE_MAX = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Starting value of the best-sum register: all-ones so any sum wins when minimising.
   function automatic logic [63:0] initial_best(input logic mode, input int width);
      if (mode == MODE_MAX) return 64'd0;
      if (width >= 64) return {64{1'b1}};
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/cost_group_acc.sv
// rtl/cost_group_acc.sv - term counter and running sum for one group of GROUP_LEN costs
module cost_group_acc
   import cost_pkg::*;
#(
   parameter int COST_W    = 7,
   parameter int GROUP_LEN = 8,
   parameter int ACC_W     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              accept,
   input  logic              last,
   input  logic [COST_W-1:0] cost,
   output logic              group_done,
   output logic [ACC_W-1:0]  group_sum,
   output logic              last_partial
);

   localparam int TCW = (clog2(GROUP_LEN) < 1) ? 1 : clog2(GROUP_LEN);

   logic [TCW-1:0]   term_cnt_q, term_cnt_d, term_base;
   logic [ACC_W-1:0] acc_q, acc_d, acc_base;

   // A term on the clear cycle is the first term of the new run.
   always_comb begin
      term_base    = clear ? '0 : term_cnt_q;
      acc_base     = clear ? '0 : acc_q;
      group_sum    = acc_base + ACC_W'(cost);
      group_done   = accept && (term_base == TCW'(GROUP_LEN - 1));
      last_partial = accept && last && !group_done;
      term_cnt_d   = term_base;
      acc_d        = acc_base;
      if (accept) begin
         if (group_done) begin
            term_cnt_d = '0;
            acc_d      = '0;
         end else begin
            term_cnt_d = term_base + TCW'(1);
            acc_d      = group_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_cnt_q <= '0;
         acc_q      <= '0;
      end else begin
         term_cnt_q <= term_cnt_d;
         acc_q      <= acc_d;
      end
   end

endmodule

// File: rtl/cost_min_param.sv
// rtl/cost_min_param.sv - tracks best group sum, tie count and first best index over a cost stream
module cost_min_param
   import cost_pkg::*;
#(
   parameter int COST_W    = 7,
   parameter int GROUP_LEN = 8,
   parameter int ACC_W     = 10,
   parameter int CNT_W     = 4,
   parameter int IDX_W     = 16
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              Start,
   input  logic              Mode,
   input  logic              In_valid,
   input  logic [COST_W-1:0] cost,
   input  logic              Last,
   output logic [ACC_W-1:0]  MinCost,
   output logic [CNT_W-1:0]  MatchCount,
   output logic [IDX_W-1:0]  BestIndex,
   output logic              Valid,
   output logic              Error,
   output logic              Busy
);

   if (GROUP_LEN < 2) begin : g_bad_group_len
      $error("cost_min_param: GROUP_LEN must be at least 2");
   end
   if (ACC_W < COST_W + clog2(GROUP_LEN)) begin : g_bad_acc_w
      $error("cost_min_param: ACC_W too narrow for a full group sum");
   end

   logic             mode_q, mode_d, mode_eff;
   logic [ACC_W-1:0] best_q, best_d, best_base, best_init;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
   logic [IDX_W-1:0] idx_q, idx_d, idx_base;
   logic [IDX_W-1:0] grp_q, grp_d, grp_base;
   logic             valid_q, valid_d;
   logic             error_q, error_d;
   logic             busy_q, busy_d;
   logic             accept, group_done, last_partial, better, tie;
   logic [ACC_W-1:0] group_sum;

   assign accept = In_valid && (busy_q || Start);

   cost_group_acc #(
      .COST_W    (COST_W),
      .GROUP_LEN (GROUP_LEN),
      .ACC_W     (ACC_W)
   ) u_acc (
      .clk          (CLK),
      .rst_n        (RST_n),
      .clear        (Start),
      .accept       (accept),
      .last         (Last),
      .cost         (cost),
      .group_done   (group_done),
      .group_sum    (group_sum),
      .last_partial (last_partial)
   );

   // On a Start cycle every comparison runs against the freshly initialised run state.
   assign mode_eff  = Start ? Mode : mode_q;
   assign best_init = ACC_W'(initial_best(Mode, ACC_W));
   assign best_base = Start ? best_init : best_q;
   assign cnt_base  = Start ? '0 : cnt_q;
   assign idx_base  = Start ? '0 : idx_q;
   assign grp_base  = Start ? '0 : grp_q;
   assign better    = (mode_eff == MODE_MAX) ? (group_sum > best_base) : (group_sum < best_base);
   assign tie       = (group_sum == best_base);

   always_comb begin
      mode_d  = Start ? Mode : mode_q;
      best_d  = best_base;
      cnt_d   = cnt_base;
      idx_d   = idx_base;
      grp_d   = grp_base;
      error_d = Start ? 1'b0 : error_q;
      busy_d  = Start ? 1'b1 : busy_q;
      valid_d = 1'b0;
      if (group_done) begin
         if (better) begin
            best_d = group_sum;
            cnt_d  = CNT_W'(1);
            idx_d  = grp_base;
         end else if (tie && !(&cnt_base)) begin
            cnt_d = cnt_base + CNT_W'(1);
         end
         if (!(&grp_base)) grp_d = grp_base + IDX_W'(1);
      end
      if (accept && Last) begin
         valid_d = 1'b1;
         busy_d  = 1'b0;
         if (last_partial) error_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         mode_q  <= MODE_MIN;
         best_q  <= '1;
         cnt_q   <= '0;
         idx_q   <= '0;
         grp_q   <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         best_q  <= best_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         grp_q   <= grp_d;
         valid_q <= valid_d;
         error_q <= error_d;
         busy_q  <= busy_d;
      end
   end

   assign MinCost    = best_q;
   assign MatchCount = cnt_q;
   assign BestIndex  = idx_q;
   assign Valid      = valid_q;
   assign Error      = error_q;
   assign Busy       = busy_q;

endmodule
